hack_run_ctrl: RTL

HACK_RUN_CTRL -- requirements
Module: hack_run_ctrl

---
 rtl/hack_run_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/hack_run_ctrl.sv
// hack_run_ctrl: run controller for a Hack CPU (reset hold, free run, single step, stop detection)
module hack_run_ctrl #(
   parameter int PC_W       = 15,
   parameter int CNT_W      = 32,
   parameter int RESET_HOLD = 1,
   parameter int MAX_CYCLES = 20,
   parameter int LOOP_HITS  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             step_mode,
   input  logic             step,
   input  logic             halt_req,
   input  logic [PC_W-1:0]  pc,
   output logic             cpu_reset,
   output logic             cpu_en,
   output logic             done,
   output logic [1:0]       stop_cause,
   output logic [CNT_W-1:0] cycle_count
);
   localparam int LW = $clog2(LOOP_HITS + 1);
   typedef enum logic [2:0] {IDLE, RST_HOLD, RUN, STEP_WAIT, STEP_ONE, DONE} state_t;
   state_t state, state_n;
   logic [7:0] hold, hold_n;
   logic [LW-1:0] loop_cnt, loop_n, loop_inc;
   logic [PC_W-1:0] prev_pc, prev_pc_n;
   logic pc_vld, pc_vld_n, en, eq, loop_hit, bud_hit, halt, stop;
   logic [CNT_W-1:0] cnt_n, cnt_inc;
   logic [1:0] cause_n;
   always_comb begin
      en       = state == RUN || state == STEP_ONE;
      cnt_inc  = &cycle_count ? cycle_count : cycle_count + 1'b1;
      eq       = pc_vld && pc == prev_pc;
      loop_inc = eq ? loop_cnt + 1'b1 : '0;
      loop_hit = en && eq && loop_inc == LW'(LOOP_HITS);
      bud_hit  = en && MAX_CYCLES != 0 && cnt_inc == CNT_W'(MAX_CYCLES);
      halt     = halt_req && (state == RUN || state == STEP_WAIT || state == STEP_ONE);
      stop     = halt || loop_hit || bud_hit;
      state_n   = state;
      hold_n    = hold;
      loop_n    = loop_cnt;
      prev_pc_n = prev_pc;
      pc_vld_n  = pc_vld;
      cnt_n     = cycle_count;
      cause_n   = stop_cause;
      if (en) begin
         cnt_n     = cnt_inc;
         loop_n    = loop_inc;
         prev_pc_n = pc;
         pc_vld_n  = 1'b1;
      end
      case (state)
         RST_HOLD: begin
            hold_n  = hold - 8'd1;
            state_n = hold > 8'd1 ? RST_HOLD : step_mode ? STEP_WAIT : RUN;
         end
         RUN:       state_n = step_mode ? STEP_WAIT : RUN;
         STEP_WAIT: state_n = !step_mode ? RUN : step ? STEP_ONE : STEP_WAIT;
         STEP_ONE:  state_n = STEP_WAIT;
         default:   state_n = state;
      endcase
      if (stop) begin
         state_n = DONE;
         cause_n = halt ? 2'd3 : loop_hit ? 2'd2 : 2'd1;
      end
      // a restart wins over any stop condition seen in the same cycle
      if (start) begin
         state_n  = RST_HOLD;
         hold_n   = 8'(RESET_HOLD);
         loop_n   = '0;
         cnt_n    = '0;
         cause_n  = 2'd0;
         pc_vld_n = 1'b0;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         hold        <= '0;
         loop_cnt    <= '0;
         prev_pc     <= '0;
         pc_vld      <= 1'b0;
         cycle_count <= '0;
         stop_cause  <= 2'd0;
         cpu_reset   <= 1'b1;
         cpu_en      <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_n;
         hold        <= hold_n;
         loop_cnt    <= loop_n;
         prev_pc     <= prev_pc_n;
         pc_vld      <= pc_vld_n;
         cycle_count <= cnt_n;
         stop_cause  <= cause_n;
         cpu_reset   <= state_n == IDLE || state_n == RST_HOLD;
         cpu_en      <= state_n == RUN || state_n == STEP_ONE;
         done        <= state_n == DONE;
      end
   end
endmodule
